// File: rtl/banco_registros_ea_param.sv
// rtl/banco_registros_ea_param.sv - 8088-style register bank with CX loop support and 2-stage EA pipeline
module banco_registros_ea_param #(
  parameter int DW         = 16,
  parameter int NREG       = 8,
  parameter int DISP8_SEXT = 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      WR,
  input  logic [$clog2(NREG)+1:0]   opEW,
  input  logic [DW-1:0]             A,
  input  logic [$clog2(NREG)+1:0]   opER,
  output logic [DW-1:0]             R,
  input  logic                      DEC_CX,
  output logic                      CXZ,
  input  logic                      EA_REQ,
  output logic                      EA_GNT,
  input  logic [1:0]                mod,
  input  logic [2:0]                RM,
  input  logic [DW-1:0]             DESP,
  output logic [DW-1:0]             RI,
  output logic                      EA_VLD,
  input  logic                      EA_ACK
);
  localparam int IW = $clog2(NREG);

  function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] old_v,
                                               input logic [1:0]    sz,
                                               input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = old_v;
    case (sz)
      2'b00:   r[7:0]  = d[7:0];
      2'b01:   r[15:8] = d[7:0];
      2'b10:   r       = d;
      default: if (DW == 32) r[15:0] = d[15:0]; else r = d;
    endcase
    return r;
  endfunction

  function automatic logic [DW-1:0] lane_read(input logic [DW-1:0] v, input logic [1:0] sz);
    logic [DW-1:0] r;
    case (sz)
      2'b00:   r = DW'(v[7:0]);
      2'b01:   r = DW'(v[15:8]);
      2'b10:   r = v;
      default: r = (DW == 32) ? DW'(v[15:0]) : v;
    endcase
    return r;
  endfunction

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  logic [DW-1:0] r_q, r_d;

  // A write to CX overrides the same-cycle decrement because it is applied last.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
      if (i == 1 && DEC_CX) regs_d[i] = regs_q[i] - DW'(1);
      if (WR && opEW[IW-1:0] == IW'(i)) regs_d[i] = lane_merge(regs_q[i], opEW[IW+1:IW], A);
    end
    r_d = lane_read(regs_d[opER[IW-1:0]], opER[IW+1:IW]);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      r_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
      r_q <= r_d;
    end
  end

  assign R   = r_q;
  assign CXZ = (regs_q[1] == '0);

  logic [DW-1:0] ea_base, ea_disp;
  logic [DW-1:0] bx, bp, si, di;

  assign bx = regs_q[3];
  assign bp = regs_q[5];
  assign si = regs_q[6];
  assign di = regs_q[7];

  always_comb begin
    ea_base = '0;
    ea_disp = '0;
    case (RM)
      3'd0: ea_base = bx + si;
      3'd1: ea_base = bx + di;
      3'd2: ea_base = bp + si;
      3'd3: ea_base = bp + di;
      3'd4: ea_base = si;
      3'd5: ea_base = di;
      3'd6: ea_base = bp;
      default: ea_base = bx;
    endcase
    case (mod)
      2'b01: ea_disp = (DISP8_SEXT != 0) ? {{(DW-8){DESP[7]}}, DESP[7:0]} : DW'(DESP[7:0]);
      2'b10: ea_disp = DESP;
      default: ea_disp = '0;
    endcase
    if (mod == 2'b00 && RM == 3'b110) begin
      ea_base = '0;
      ea_disp = DESP;
    end
  end

  logic          s1_full_q, s1_full_d;
  logic [DW-1:0] s1_base_q, s1_disp_q;
  logic [DW-1:0] ri_q;
  logic          ea_vld_q;
  logic          s2_free, s1_adv, ea_acc;

  assign s2_free   = !ea_vld_q || EA_ACK;
  assign s1_adv    = s1_full_q && s2_free;
  assign EA_GNT    = !s1_full_q || s1_adv;
  assign ea_acc    = EA_REQ && EA_GNT;
  assign s1_full_d = ea_acc || (s1_full_q && !s1_adv);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1_full_q <= 1'b0;
      s1_base_q <= '0;
      s1_disp_q <= '0;
      ri_q      <= '0;
      ea_vld_q  <= 1'b0;
    end else begin
      s1_full_q <= s1_full_d;
      if (ea_acc) begin
        s1_base_q <= ea_base;
        s1_disp_q <= ea_disp;
      end
      if (s1_adv) begin
        ri_q     <= s1_base_q + s1_disp_q;
        ea_vld_q <= 1'b1;
      end else if (EA_ACK) begin
        ea_vld_q <= 1'b0;
      end
    end
  end

  assign RI     = ri_q;
  assign EA_VLD = ea_vld_q;
endmodule
